// File: rtl/piece_mover.sv
// piece_mover: moves a four-cell falling piece one step (down/left/right) inside a byte-per-cell
// grid memory. A move first reads the four target cells for collisions, then reads the piece
// byte from cell 0, clears the four old cells and writes the piece byte to the four targets.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   load, load_addr   one-cycle pulse latching four cell addresses (cell 0 in the LSBs)
//   move_valid/dir    move request (00 down, 01 left, 10 right, 11 ignored), held until accepted
//   move_ready        high in IDLE with a piece loaded and no gravity step pending
//   tetris_grid_in    grid read data, valid one clock after grid_address
//   grid_address      grid memory address
//   grid_data_out     grid write data, write_en its strobe
//   done              one-cycle pulse when a move commits
//   landed / blocked  one-cycle pulse when a down / sideways move collides
//
// Optional feature: define PIECE_MOVER_GRAVITY_EN to add a tick counter that requests a down
// step every TICK_INTERVAL clocks while a piece is loaded.
module piece_mover #(
  parameter int GRID_COLS     = 12,
  parameter int ADDR_W        = 8,
  parameter int TICK_INTERVAL = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*ADDR_W-1:0] load_addr,
  input  logic                move_valid,
  input  logic [1:0]          move_dir,
  output logic                move_ready,
  input  logic [7:0]          tetris_grid_in,
  output logic [ADDR_W-1:0]   grid_address,
  output logic [7:0]          grid_data_out,
  output logic                write_en,
  output logic                done,
  output logic                landed,
  output logic                blocked
);

  typedef enum logic [2:0] {
    StIdle, StChkAddr, StChkRead, StRdAddr, StRdData, StClear, StWrite, StDone
  } state_e;

  localparam logic [1:0] DirDown = 2'b00;
  localparam logic [1:0] DirLeft = 2'b01;
  localparam logic [1:0] DirNone = 2'b11;

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [1:0]        dir_q;
  logic [ADDR_W-1:0] pos_q [4];
  logic              loaded_q;
  logic              coll_q;
  logic [7:0]        piece_q;
  logic              pending_q;
  logic              grav_start;
  logic              accept;
  logic              hit;
  logic              coll_all;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] p,
                                                  input logic [1:0]        d);
    logic [ADDR_W-1:0] r;
    case (d)
      DirDown: r = p + ADDR_W'(GRID_COLS);
      DirLeft: r = p - ADDR_W'(1);
      default: r = p + ADDR_W'(1);
    endcase
    return r;
  endfunction

  // Active cells (bit 7) belong to the moving piece and never block it.
  assign hit      = (tetris_grid_in[3:0] != 4'd0) && !tetris_grid_in[7];
  assign coll_all = coll_q | hit;

  assign move_ready = !reset && (state_q == StIdle) && loaded_q && !pending_q && !load;
  assign accept     = move_ready && move_valid;
  assign grav_start = (state_q == StIdle) && loaded_q && pending_q;

`ifdef PIECE_MOVER_GRAVITY_EN
  localparam int CntW = $clog2(TICK_INTERVAL + 1);
  logic [CntW-1:0] tick_cnt_q;
  logic            tick;

  assign tick = loaded_q && (tick_cnt_q == CntW'(TICK_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (reset || !loaded_q || tick) tick_cnt_q <= '0;
    else                            tick_cnt_q <= tick_cnt_q + CntW'(1);
  end

  // A tick on the same edge the pending step starts is the next step, so it wins.
  always_ff @(posedge clk) begin
    if (reset || !loaded_q) pending_q <= 1'b0;
    else if (tick)          pending_q <= 1'b1;
    else if (grav_start)    pending_q <= 1'b0;
  end
`else
  logic unused_tick_cfg;
  assign unused_tick_cfg = (TICK_INTERVAL == 0);
  assign pending_q       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= 2'd0;
      dir_q         <= DirDown;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      loaded_q      <= 1'b0;
      coll_q        <= 1'b0;
      piece_q       <= 8'h00;
      grid_address  <= '0;
      grid_data_out <= 8'h00;
      write_en      <= 1'b0;
      done          <= 1'b0;
      landed        <= 1'b0;
      blocked       <= 1'b0;
    end else begin
      done    <= 1'b0;
      landed  <= 1'b0;
      blocked <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grav_start) begin
            dir_q        <= DirDown;
            coll_q       <= 1'b0;
            grid_address <= step_addr(pos_q[0], DirDown);
            state_q      <= StChkAddr;
          end else if (accept) begin
            if (move_dir != DirNone) begin
              dir_q        <= move_dir;
              coll_q       <= 1'b0;
              grid_address <= step_addr(pos_q[0], move_dir);
              state_q      <= StChkAddr;
            end
          end else if (load) begin
            for (int i = 0; i < 4; i++) pos_q[i] <= load_addr[i*ADDR_W +: ADDR_W];
            loaded_q <= 1'b1;
          end
        end
        StChkAddr: begin
          grid_address <= step_addr(pos_q[1], dir_q);
          idx_q        <= 2'd0;
          state_q      <= StChkRead;
        end
        StChkRead: begin
          // Reads are pipelined: while checking cell i the address of cell i+2 goes out.
          coll_q <= coll_all;
          if (idx_q == 2'd3) begin
            if (coll_all) begin
              state_q <= StIdle;
              if (dir_q == DirDown) begin
                landed   <= 1'b1;
                loaded_q <= 1'b0;
              end else begin
                blocked <= 1'b1;
              end
            end else begin
              grid_address <= pos_q[0];
              state_q      <= StRdAddr;
            end
          end else begin
            idx_q        <= idx_q + 2'd1;
            grid_address <= step_addr(pos_q[idx_q + 2'd2], dir_q);
          end
        end
        StRdAddr: state_q <= StRdData;
        StRdData: begin
          piece_q       <= tetris_grid_in;
          grid_address  <= pos_q[0];
          grid_data_out <= 8'h00;
          write_en      <= 1'b1;
          idx_q         <= 2'd0;
          state_q       <= StClear;
        end
        StClear: begin
          if (idx_q == 2'd3) begin
            idx_q         <= 2'd0;
            grid_address  <= step_addr(pos_q[0], dir_q);
            grid_data_out <= piece_q;
            state_q       <= StWrite;
          end else begin
            idx_q        <= idx_q + 2'd1;
            grid_address <= pos_q[idx_q + 2'd1];
          end
        end
        StWrite: begin
          if (idx_q == 2'd3) begin
            write_en <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end else begin
            idx_q        <= idx_q + 2'd1;
            grid_address <= step_addr(pos_q[idx_q + 2'd1], dir_q);
          end
        end
        StDone: begin
          for (int i = 0; i < 4; i++) pos_q[i] <= step_addr(pos_q[i], dir_q);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter GRID_COLS, default 12, cells per row including both border columns.
REQ-002 SHALL have parameter ADDR_W, default 8, grid address width.
REQ-003 SHALL have parameter TICK_INTERVAL, default 200, clocks between gravity steps.
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load  input  1  one-cycle pulse, latch new piece addresses.
REQ-007 SHALL have port load_addr  input  4*ADDR_W  four cell addresses, cell 0 in LSBs.
REQ-008 SHALL have port move_valid  input  1  move request, held until accepted.
REQ-009 SHALL have port move_dir  input  2  00 down, 01 left, 10 right, 11 reserved.
REQ-010 SHALL have port move_ready  output  1  high only in IDLE with a piece loaded and no pending gravity step.
REQ-011 SHALL have port tetris_grid_in  input  8  grid read data, valid one clock after grid_address.
REQ-012 SHALL have port grid_address  output  ADDR_W  grid memory address.
REQ-013 SHALL have port grid_data_out  output  8  grid write data.
REQ-014 SHALL have port write_en  output  1  grid write strobe.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a move commits.
REQ-016 SHALL have port landed  output  1  one-cycle pulse when a down move collides; piece then unloaded.
REQ-017 SHALL have port blocked  output  1  one-cycle pulse when a left/right move collides.

Function
REQ-018 SHALL accept a move when move_valid and move_ready are both high at a clock edge; move_dir 11 is accepted and discarded with no pulse.
REQ-019 SHALL compute targets: down = pos+GRID_COLS, left = pos-1, right = pos+1, modulo 2^ADDR_W.
REQ-020 SHALL sequence states IDLE -> CHK_ADDR -> CHK_READ (x4, cells 0..3) -> RD_ADDR -> RD_DATA -> CLEAR (x4) -> WRITE (x4) -> DONE -> IDLE.
REQ-021 SHALL, in CHK_READ, flag collision when tetris_grid_in[3:0] != 0 and tetris_grid_in[7] == 0; active cells (bit 7 set) never collide.
REQ-022 SHALL, on collision after the 4th check, return to IDLE with no writes and pulse landed (down) or blocked (left/right).
REQ-023 SHALL capture cell 0 data in RD_DATA and write it unchanged to all four targets.
REQ-024 SHALL write 0 to all four old addresses before writing any target, so overlapping old/target cells end holding piece data.
REQ-025 SHALL assert write_en only in CLEAR and WRITE states, exactly 8 cycles per committed move.
REQ-026 SHALL update all four stored positions to targets in DONE and pulse done there.
REQ-027 SHALL have latency 16 clocks from accept to done pulse for a committed move.
REQ-028 SHALL ignore load while not in IDLE; load in IDLE overrides positions and marks the piece loaded.
REQ-029 SHALL hold move_ready low and treat moves as not accepted while no piece is loaded.

Reset
REQ-030 SHALL, on reset, enter IDLE, clear positions, piece-loaded flag, tick counter and pending flag.
REQ-031 SHALL drive grid_address 0, grid_data_out 0, write_en 0, done/landed/blocked 0, move_ready 0 during and after reset.
REQ-032 SHALL abort any move in progress on reset mid-sequence; partial grid writes are not undone.

Configuration
REQ-033 SHALL, with macro PIECE_MOVER_GRAVITY_EN defined, count clocks while a piece is loaded and raise a pending down step when the count reaches TICK_INTERVAL, then restart the count from 0.
REQ-034 SHALL, with PIECE_MOVER_GRAVITY_EN defined, run a pending step from IDLE before any user request; a user request on the same edge is not accepted and stays held.
REQ-035 SHALL, with PIECE_MOVER_GRAVITY_EN defined, hold at most one pending step; a tick during a busy sequence is kept, a second is dropped.
REQ-036 SHALL, without PIECE_MOVER_GRAVITY_EN, contain no tick counter; down moves occur only through move_valid.

Verification
REQ-037 SHALL cover: load {100,101,102,103}, empty grid, move down -> done at accept+16, cells 112..115 hold piece data, 100..103 read 0.
REQ-038 SHALL cover: piece at {100,112,124,136}, move down -> cell 112 overlap ends with piece data, 100 is 0.
REQ-039 SHALL cover: cell 104 = 0x08 border, piece at {100..103}, move right -> blocked pulse, zero write_en cycles, positions unchanged.
REQ-040 SHALL cover: cell 113 = 0x03 settled, move down -> landed pulse, move_ready stays 0 until next load.
REQ-041 SHALL cover: GRAVITY_EN, TICK_INTERVAL 20, no requests -> down move committed every tick; tick coincident with a left request -> down first, then left.
REQ-042 SHALL cover: reset asserted in the 3rd CLEAR cycle -> next cycle all outputs 0, state IDLE, move_ready 0.
